// File: rtl/pe_row_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_row_seq_if : weight-write, feature-beat and result bus of the PE row |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pe_row_seq_if #(
  parameter int PE_DIM     = 8,
  parameter int FEAT_WIDTH = 8,
  parameter int WGT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int WGT_DEPTH  = 16
);
  localparam int IDX_W  = (WGT_DEPTH > 1) ? $clog2(WGT_DEPTH) : 1;
  localparam int LANE_W = (PE_DIM > 1) ? $clog2(PE_DIM) : 1;

  logic                  w_we;
  logic [LANE_W-1:0]     w_lane;
  logic [IDX_W-1:0]      w_addr;
  logic [WGT_WIDTH-1:0]  w_data;
  logic                  f_valid;
  logic                  f_ready;
  logic [FEAT_WIDTH-1:0] f_data;
  logic [IDX_W-1:0]      f_idx;
  logic                  f_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic [LANE_W-1:0]     out_lane;

  modport master (
    output w_we, w_lane, w_addr, w_data,
    output f_valid, f_data, f_idx, f_last,
    input  f_ready,
    input  out_valid, out_data, out_lane,
    output out_ready
  );

  modport slave (
    input  w_we, w_lane, w_addr, w_data,
    input  f_valid, f_data, f_idx, f_last,
    output f_ready,
    output out_valid, out_data, out_lane,
    input  out_ready
  );
endinterface
`default_nettype wire

// File: rtl/pe_row_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_row_seq : PE_DIM signed MAC lanes fed by broadcast sparse features, |
// | results drained lane by lane. Rev 1.0. PE_ROW_SEQ_SATURATE_EN = clamp. |
// +----------------------------------------------------------------------+
module pe_row_seq #(
  parameter int PE_DIM     = 8,
  parameter int FEAT_WIDTH = 8,
  parameter int WGT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int WGT_DEPTH  = 16
) (
  input wire logic    clk,
  input wire logic    reset,
  pe_row_seq_if.slave bus
);
  localparam int IDX_W  = (WGT_DEPTH > 1) ? $clog2(WGT_DEPTH) : 1;
  localparam int LANE_W = (PE_DIM > 1) ? $clog2(PE_DIM) : 1;
  localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(PE_DIM - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [LANE_W-1:0]           cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q [PE_DIM];
  logic signed [ACC_WIDTH-1:0] acc_d [PE_DIM];
  logic signed [WGT_WIDTH-1:0] wgt_q [PE_DIM][WGT_DEPTH];
  logic signed [WGT_WIDTH-1:0] wgt_d [PE_DIM][WGT_DEPTH];

  // One extra sum bit exposes signed overflow for the clamp.
  function automatic logic signed [ACC_WIDTH-1:0] mac(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [FEAT_WIDTH-1:0] f,
    input logic signed [WGT_WIDTH-1:0]  w
  );
    logic signed [FEAT_WIDTH+WGT_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH:0]              sum;
    prod = f * w;
    sum  = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(prod);
`ifdef PE_ROW_SEQ_SATURATE_EN
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      mac = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      mac = sum[ACC_WIDTH-1:0];
    end
`else
    mac = sum[ACC_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wgt_d   = wgt_q;
    case (state_q)
      ACCUM: begin
        if (bus.f_valid) begin
          for (int l = 0; l < PE_DIM; l++) begin
            acc_d[l] = mac(acc_q[l], bus.f_data, wgt_q[l][bus.f_idx]);
          end
          if (bus.f_last) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (cnt_q == c_last_lane) begin
            for (int l = 0; l < PE_DIM; l++) begin
              acc_d[l] = '0;
            end
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
    // The MAC above read wgt_q, so a colliding write lands one cycle later.
    for (int l = 0; l < PE_DIM; l++) begin
      if (bus.w_we && (bus.w_lane == LANE_W'(l))) begin
        wgt_d[l][bus.w_addr] = bus.w_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      for (int l = 0; l < PE_DIM; l++) begin
        acc_q[l] <= '0;
        for (int a = 0; a < WGT_DEPTH; a++) begin
          wgt_q[l][a] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wgt_q   <= wgt_d;
    end
  end

  assign bus.f_ready   = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = (state_q == DRAIN) ? acc_q[cnt_q] : '0;
  assign bus.out_lane  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_row_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pe_row_seq : directed bench for pe_row_seq (PE_DIM=4, ACC_WIDTH=16) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pe_row_seq;
  localparam int PE_DIM     = 4;
  localparam int FEAT_WIDTH = 8;
  localparam int WGT_WIDTH  = 8;
  localparam int ACC_WIDTH  = 16;
  localparam int WGT_DEPTH  = 16;
`ifdef PE_ROW_SEQ_SATURATE_EN
  localparam int c_ovf_exp = 32767;
`else
  localparam int c_ovf_exp = 15109;
`endif

  logic clk;
  logic reset;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  pe_row_seq_if #(
    .PE_DIM(PE_DIM), .FEAT_WIDTH(FEAT_WIDTH), .WGT_WIDTH(WGT_WIDTH),
    .ACC_WIDTH(ACC_WIDTH), .WGT_DEPTH(WGT_DEPTH)
  ) bus ();

  pe_row_seq #(
    .PE_DIM(PE_DIM), .FEAT_WIDTH(FEAT_WIDTH), .WGT_WIDTH(WGT_WIDTH),
    .ACC_WIDTH(ACC_WIDTH), .WGT_DEPTH(WGT_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int lane, input int addr, input int data);
    bus.w_we   = 1'b1;
    bus.w_lane = 2'(lane);
    bus.w_addr = 4'(addr);
    bus.w_data = 8'(data);
    step();
    bus.w_we   = 1'b0;
  endtask

  task automatic beat(input int d, input int idx, input bit last);
    chk("beat_f_ready", bus.f_ready, 1);
    bus.f_valid = 1'b1;
    bus.f_data  = 8'(d);
    bus.f_idx   = 4'(idx);
    bus.f_last  = last;
    step();
    bus.f_valid = 1'b0;
    bus.f_last  = 1'b0;
  endtask

  task automatic drain(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_valid"}, bus.out_valid, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < PE_DIM; i++) begin
      chk({tag, "_lane"}, bus.out_lane, i);
      chk({tag, "_data"}, $signed(bus.out_data), e[i]);
      step();
    end
    bus.out_ready = 1'b0;
    chk({tag, "_done_valid"}, bus.out_valid, 0);
    chk({tag, "_done_ready"}, bus.f_ready, 1);
  endtask

  initial begin
    reset         = 1'b0;
    bus.w_we      = 1'b0;
    bus.w_lane    = '0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.f_valid   = 1'b0;
    bus.f_data    = '0;
    bus.f_idx     = '0;
    bus.f_last    = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_f_ready", bus.f_ready, 1);
    chk("rst_out_data", $signed(bus.out_data), 0);
    chk("rst_out_lane", bus.out_lane, 0);
    #2 reset = 1'b1;
    step();

    // Basic two-beat vector: lane l gets 2*(l+1) - (l+1) = l+1.
    for (int l = 0; l < PE_DIM; l++) wr(l, 3, l + 1);
    beat(2, 3, 1'b0);
    beat(-1, 3, 1'b1);
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_f_ready", bus.f_ready, 0);
    bus.out_ready = 1'b1;
    chk("basic_lane0", bus.out_lane, 0);
    chk("basic_data0", $signed(bus.out_data), 1);
    step();

    // Backpressure at lane 1 with a beat offered during DRAIN.
    bus.out_ready = 1'b0;
    bus.f_valid   = 1'b1;
    bus.f_data    = 8'd5;
    bus.f_idx     = 4'd3;
    bus.f_last    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_lane", bus.out_lane, 1);
      chk("bp_data", $signed(bus.out_data), 2);
      chk("bp_f_ready", bus.f_ready, 0);
      step();
    end
    bus.f_valid   = 1'b0;
    bus.f_last    = 1'b0;
    bus.out_ready = 1'b1;
    for (int l = 1; l < PE_DIM; l++) begin
      chk("basic_lane", bus.out_lane, l);
      chk("basic_data", $signed(bus.out_data), l + 1);
      step();
    end
    bus.out_ready = 1'b0;
    chk("basic_done_valid", bus.out_valid, 0);
    chk("basic_done_ready", bus.f_ready, 1);

    // Single-beat vector on freshly cleared accumulators.
    beat(1, 3, 1'b1);
    drain("single", 1, 2, 3, 4);

    // Overflow: 5 * 127 * 127 = 80645.
    for (int l = 0; l < PE_DIM; l++) wr(l, 5, 127);
    for (int k = 0; k < 4; k++) beat(127, 5, 1'b0);
    beat(127, 5, 1'b1);
    drain("ovf", c_ovf_exp, c_ovf_exp, c_ovf_exp, c_ovf_exp);

    // Write/MAC collision on lane 0 entry 0: MAC sees the old weight.
    wr(0, 0, 2);
    chk("coll_f_ready", bus.f_ready, 1);
    bus.w_we    = 1'b1;
    bus.w_lane  = 2'd0;
    bus.w_addr  = 4'd0;
    bus.w_data  = 8'd5;
    bus.f_valid = 1'b1;
    bus.f_data  = 8'd1;
    bus.f_idx   = 4'd0;
    bus.f_last  = 1'b1;
    step();
    bus.w_we    = 1'b0;
    bus.f_valid = 1'b0;
    bus.f_last  = 1'b0;
    drain("coll_old", 2, 0, 0, 0);
    beat(1, 0, 1'b1);
    drain("coll_new", 5, 0, 0, 0);

    // Reset after the lane-1 handshake.
    beat(1, 0, 1'b1);
    chk("mid_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    chk("mid_lane2", bus.out_lane, 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_f_ready", bus.f_ready, 1);
    chk("mid_rst_data", $signed(bus.out_data), 0);
    chk("mid_rst_lane", bus.out_lane, 0);
    #2 reset = 1'b1;
    step();
    chk("post_rst_valid", bus.out_valid, 0);
    beat(1, 0, 1'b1);
    drain("post_rst0", 0, 0, 0, 0);
    beat(1, 3, 1'b1);
    drain("post_rst3", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_row_seq.md
PE_ROW_SEQ -- requirements
Module: pe_row_seq

Interface
REQ-001 SHALL have parameter PE_DIM, default 8: number of MAC lanes in the row; legal range 2..64.
REQ-002 SHALL have parameter FEAT_WIDTH, default 8: signed feature width.
REQ-003 SHALL have parameter WGT_WIDTH, default 8: signed weight width.
REQ-004 SHALL have parameter ACC_WIDTH, default 24: signed accumulator/output width; must be at least FEAT_WIDTH+WGT_WIDTH.
REQ-005 SHALL have parameter WGT_DEPTH, default 16: weight entries per lane; must be a power of two, at least 2.
REQ-006 SHALL use derived widths IDX_W = log2(WGT_DEPTH) and LANE_W = log2(PE_DIM), minimum 1.
REQ-007 SHALL have these ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- w_we  in  1  weight write strobe.
- w_lane  in  LANE_W  target lane.
- w_addr  in  IDX_W  weight entry.
- w_data  in  WGT_WIDTH  weight value.
- f_valid  in  1  feature beat valid.
- f_ready  out  1  feature beat accept.
- f_data  in  FEAT_WIDTH  non-zero feature value, broadcast to all lanes.
- f_idx  in  IDX_W  feature index; selects the weight entry.
- f_last  in  1  last non-zero of the vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_data  out  ACC_WIDTH  lane result.
- out_lane  out  LANE_W  lane number of out_data.

Function
REQ-008 SHALL have two states, ACCUM and DRAIN, held in a state register.
REQ-009 In ACCUM, f_ready SHALL be 1 and out_valid SHALL be 0; in DRAIN, f_ready SHALL be 0 and out_valid SHALL be 1.
REQ-010 On each f_valid&&f_ready cycle, every lane l SHALL register acc[l] += f_data * wgt[l][f_idx]. The product is signed and sign-extended to ACC_WIDTH. Wrap-around applies unless REQ-021 is in effect.
REQ-011 A beat with f_last=1 SHALL be accumulated, and the state SHALL move to DRAIN on the next edge with lane counter = 0. out_valid SHALL rise one cycle after the f_last handshake.
REQ-012 In DRAIN, out_data SHALL equal acc[cnt] and out_lane SHALL equal cnt. Both SHALL stay stable while out_ready=0.
REQ-013 On an out_valid&&out_ready cycle, cnt SHALL increment.
REQ-014 On the handshake at cnt=PE_DIM-1: all accumulators SHALL clear to 0, cnt SHALL return to 0 and the state SHALL return to ACCUM. f_ready SHALL be 1 on the following cycle, giving one bubble per vector.
REQ-015 f_valid during DRAIN SHALL be ignored; upstream must hold the beat.
REQ-016 Weight writes SHALL be accepted in any state. A write with w_lane >= PE_DIM SHALL be ignored.
REQ-017 If a weight write and a feature beat target the same lane and entry in the same cycle, the MAC SHALL use the old weight and the new weight SHALL take effect the next cycle.
REQ-018 A vector consisting of a single beat with f_last=1 SHALL be legal.

Reset
REQ-019 While reset=0, asynchronously:
- state = ACCUM, cnt = 0;
- all accumulators and all weight entries = 0;
- out_valid = 0, out_data = 0, out_lane = 0, f_ready = 1.
REQ-020 Reset asserted mid-DRAIN or mid-vector SHALL discard all partial results; no result is output for the aborted vector.

Configuration
REQ-021 With macro PE_ROW_SEQ_SATURATE_EN defined, each accumulate SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Without it, accumulation SHALL wrap modulo 2^ACC_WIDTH. Port list and timing SHALL be identical in both builds.

Verification
REQ-022 Basic (PE_DIM=4): set weight lane l, addr 3 = l+1; send beats (2, idx 3) then (-1, idx 3, last) -> out_data 1,2,3,4 with out_lane 0..3, first out_valid one cycle after the last beat.
REQ-023 Backpressure: hold out_ready=0 for 3 cycles at cnt=1 -> out_data and out_lane stay constant, and f_valid=1 in that window is not accepted.
REQ-024 Overflow (ACC_WIDTH=16): weights 127, five beats of 127 (sum 80645) -> 32767 with PE_ROW_SEQ_SATURATE_EN, 15109 without.
REQ-025 Collision: lane 0 addr 0 = 2; in the same cycle write 5 and send beat (1, idx 0, last) -> lane 0 result 2; the next vector with the same beat gives 5.
REQ-026 Reset mid-drain: assert reset after the lane-1 handshake -> out_valid 0 immediately; afterwards beat (1, idx 0, last) yields 0 on all lanes, since weights were cleared.
